regfile_port_arbiter: RTL and testbench

//  Shares the single sel/wr/addr/wdata/rdata port of the 4x16 register bank among N_REQ requesters.

---
 rtl/regfile_arb_pkg.sv | 13 +
 rtl/regfile_port_arbiter_rr_pick.sv | 33 +++
 rtl/regfile_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_regfile_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types and default widths for the register-bank port arbiter family.
package regfile_arb_pkg;

  localparam int unsigned DEF_AW = 2;
  localparam int unsigned DEF_DW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

endpackage

// File: rtl/regfile_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning ptr, ptr+1, ... mod N_REQ.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    grant,
  output logic             any_req
);

  logic          found;
  int unsigned   idx;
  logic [PW-1:0] idx_pw;

  // Scan from ptr upward with wrap; the first requester seen wins.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    idx     = 0;
    idx_pw  = '0;
    any_req = |req;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx    = (32'(ptr) + i) % N_REQ;
      idx_pw = PW'(idx);
      if (!found && req[idx_pw]) begin
        grant = idx_pw;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the single register-bank port among N_REQ requesters with round-robin
// arbitration and a bounded lock for read-modify-write sequences.
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    req_we,
  input  logic [N_REQ-1:0]    req_lock,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]    ack,
  output logic [DW-1:0]       rsp_rdata,
  output logic                rf_sel,
  output logic                rf_wr,
  output logic [AW-1:0]       rf_addr,
  output logic [DW-1:0]       rf_wdata,
  input  logic [DW-1:0]       rf_rdata,
  output logic                busy
);

  localparam int unsigned PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned LCW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    last_q, last_d;
  logic [PW-1:0]    win_q, win_d;
  logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [DW-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic             rf_sel_q, rf_sel_d;
  logic             rf_wr_q, rf_wr_d;
  logic [AW-1:0]    rf_addr_q, rf_addr_d;
  logic [DW-1:0]    rf_wdata_q, rf_wdata_d;
  logic             busy_q, busy_d;

  logic [PW-1:0]    rr_grant;
  logic             any_req;
  logic             lock_hit;
  logic [PW-1:0]    pick;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr_q),
    .grant   (rr_grant),
    .any_req (any_req)
  );

  // Locked requester keeps the port until its grant budget is used up.
  always_comb begin
    lock_hit = req_lock[last_q] && req[last_q] && (lock_cnt_q < LCW'(MAX_LOCK - 1));
    pick     = lock_hit ? last_q : rr_grant;
  end

  // Next-state and registered-output computation for IDLE -> ACCESS -> ACK.
  // The rf_* output registers double as the latch for the granted access;
  // rf_wr_q still holds the access direction during ACCESS for the data capture.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    last_d      = last_q;
    win_d       = win_q;
    lock_cnt_d  = lock_cnt_q;
    ack_d       = '0;
    rsp_rdata_d = '0;
    rf_sel_d    = 1'b0;
    rf_wr_d     = 1'b0;
    rf_addr_d   = rf_addr_q;
    rf_wdata_d  = rf_wdata_q;
    busy_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d    = ACCESS;
          win_d      = pick;
          lock_cnt_d = lock_hit ? lock_cnt_q + 1'b1 : '0;
          rf_sel_d   = 1'b1;
          rf_wr_d    = req_we[pick];
          rf_addr_d  = req_addr[32'(pick)*AW +: AW];
          rf_wdata_d = req_wdata[32'(pick)*DW +: DW];
          busy_d     = 1'b1;
        end
      end
      ACCESS: begin
        state_d       = ACK;
        ack_d[win_q]  = 1'b1;
        rsp_rdata_d   = rf_wr_q ? '0 : rf_rdata;
        busy_d        = 1'b1;
      end
      ACK: begin
        state_d = IDLE;
        last_d  = win_q;
        ptr_d   = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      last_q      <= '0;
      win_q       <= '0;
      lock_cnt_q  <= '0;
      ack_q       <= '0;
      rsp_rdata_q <= '0;
      rf_sel_q    <= 1'b0;
      rf_wr_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_wdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      last_q      <= last_d;
      win_q       <= win_d;
      lock_cnt_q  <= lock_cnt_d;
      ack_q       <= ack_d;
      rsp_rdata_q <= rsp_rdata_d;
      rf_sel_q    <= rf_sel_d;
      rf_wr_q     <= rf_wr_d;
      rf_addr_q   <= rf_addr_d;
      rf_wdata_q  <= rf_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign ack       = ack_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rf_sel    = rf_sel_q;
  assign rf_wr     = rf_wr_q;
  assign rf_addr   = rf_addr_q;
  assign rf_wdata  = rf_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Scoreboard bench for regfile_port_arbiter with a behavioural 4x16 register bank.
module tb_regfile_port_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req, req_we, req_lock;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  ack;
  logic [15:0] rsp_rdata;
  logic        rf_sel, rf_wr;
  logic [1:0]  rf_addr;
  logic [15:0] rf_wdata, rf_rdata;
  logic        busy;

  typedef struct {
    int          who;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          ack_cyc[$];
  int          rem[4];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic        mon_en   = 1'b0;
  logic        prev_sel = 1'b0;
  logic [15:0] bank[4];

  regfile_port_arbiter #(
    .N_REQ    (4),
    .AW       (2),
    .DW       (16),
    .MAX_LOCK (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_we    (req_we),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .rsp_rdata (rsp_rdata),
    .rf_sel    (rf_sel),
    .rf_wr     (rf_wr),
    .rf_addr   (rf_addr),
    .rf_wdata  (rf_wdata),
    .rf_rdata  (rf_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Register bank: synchronous write, combinational read while selected.
  always @(posedge clk) if (rf_sel && rf_wr) bank[rf_addr] <= rf_wdata;
  assign rf_rdata = (rf_sel && !rf_wr) ? bank[rf_addr] : 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_ack(input int who, input logic [15:0] d);
    exp_t e;
    e.who  = who;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic we, input logic [1:0] a, input logic [15:0] d);
    req_we[i]            = we;
    req_addr[i*2 +: 2]   = a;
    req_wdata[i*16 +: 16] = d;
  endtask

  // Hold requests; each requester drops req after its rem[] acks. Bounded wait.
  task automatic serve(input int budget);
    int c;
    c = 0;
    while ((req != 4'b0 || busy) && c < budget) begin
      @(negedge clk);
      c++;
      for (int i = 0; i < 4; i++) begin
        if (ack[i]) begin
          ack_cyc.push_back(cyc);
          rem[i]--;
          if (rem[i] <= 0) req[i] = 1'b0;
        end
      end
    end
    check("serve_timeout", {31'b0, (req != 4'b0 || busy)}, 32'd0);
    req = 4'b0;
  endtask

  // Monitor: protocol invariants every cycle and scoreboard pop on each ack.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      check("ack_onehot", {31'b0, $onehot0(ack)}, 32'd1);
      check("busy_state", {31'b0, busy}, {31'b0, (rf_sel || ack != 4'b0)});
      if (ack == 4'b0) check("rsp_idle_zero", {16'b0, rsp_rdata}, 32'd0);
      if (rf_sel) check("sel_single_cycle", {31'b0, prev_sel}, 32'd0);
      prev_sel = rf_sel;
      if (ack != 4'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", {28'b0, ack}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ack_who", {28'b0, ack}, 32'(1) << e.who);
          check("ack_rdata", {16'b0, rsp_rdata}, {16'b0, e.data});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    req       = 4'b0;
    req_we    = 4'b0;
    req_lock  = 4'b0;
    req_addr  = 8'b0;
    req_wdata = 64'b0;
    for (int i = 0; i < 4; i++) begin
      bank[i] = 16'h0;
      rem[i]  = 0;
    end

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sel",   {31'b0, rf_sel}, 32'd0);
    check("rst_wr",    {31'b0, rf_wr}, 32'd0);
    check("rst_addr",  {30'b0, rf_addr}, 32'd0);
    check("rst_wdata", {16'b0, rf_wdata}, 32'd0);
    check("rst_ack",   {28'b0, ack}, 32'd0);
    check("rst_rsp",   {16'b0, rsp_rdata}, 32'd0);
    check("rst_busy",  {31'b0, busy}, 32'd0);
    rst    = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Single write from requester 2, port drive one cycle after sampling
    set_req(2, 1'b1, 2'd1, 16'hBEEF);
    req = 4'b0100;
    expect_ack(2, 16'h0);
    @(negedge clk);
    check("wr_sel",   {31'b0, rf_sel}, 32'd1);
    check("wr_wr",    {31'b0, rf_wr}, 32'd1);
    check("wr_addr",  {30'b0, rf_addr}, 32'd1);
    check("wr_wdata", {16'b0, rf_wdata}, 32'h0000BEEF);
    rem[2] = 1;
    serve(20);

    // Read back
    set_req(2, 1'b0, 2'd1, 16'h0);
    req = 4'b0100;
    expect_ack(2, 16'hBEEF);
    rem[2] = 1;
    serve(20);

    // ptr=3: requester 3 first, then wrap to 0
    set_req(3, 1'b0, 2'd1, 16'h0);
    set_req(0, 1'b1, 2'd0, 16'h1111);
    req = 4'b1001;
    expect_ack(3, 16'hBEEF);
    expect_ack(0, 16'h0);
    rem[3] = 1;
    rem[0] = 1;
    serve(30);

    // Reset mid-ACCESS (ptr is 1 here): no ack, back to idle, ptr cleared
    set_req(1, 1'b1, 2'd3, 16'h1234);
    req = 4'b0010;
    @(negedge clk);
    check("abort_sel_before", {31'b0, rf_sel}, 32'd1);
    rst = 1'b0;
    req = 4'b0;
    @(negedge clk);
    check("abort_sel",  {31'b0, rf_sel}, 32'd0);
    check("abort_ack",  {28'b0, ack}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    set_req(0, 1'b0, 2'd0, 16'h0);
    set_req(3, 1'b0, 2'd1, 16'h0);
    req = 4'b1001;
    expect_ack(0, 16'h1111);
    expect_ack(3, 16'hBEEF);
    rem[0] = 1;
    rem[3] = 1;
    serve(30);

    // All four requesting, no lock: 0,1,2,3,0 at 3-cycle spacing
    set_req(0, 1'b0, 2'd0, 16'h0);
    set_req(1, 1'b0, 2'd1, 16'h0);
    set_req(2, 1'b0, 2'd2, 16'h0);
    set_req(3, 1'b1, 2'd2, 16'h5A5A);
    req = 4'b1111;
    rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
    expect_ack(0, 16'h1111);
    expect_ack(1, 16'hBEEF);
    expect_ack(2, 16'h0);
    expect_ack(3, 16'h0);
    expect_ack(0, 16'h1111);
    ack_cyc.delete();
    serve(60);
    check("rr_ack_count", ack_cyc.size(), 32'd5);
    for (int i = 1; i < ack_cyc.size(); i++)
      check("rr_spacing", ack_cyc[i] - ack_cyc[i-1], 32'd3);

    // Lock on requester 1: four grants, then round-robin from ptr reaches 0
    set_req(1, 1'b0, 2'd2, 16'h0);
    set_req(0, 1'b1, 2'd3, 16'h0F0F);
    req_lock = 4'b0010;
    req      = 4'b0011;
    rem[1] = 5;
    rem[0] = 1;
    for (int i = 0; i < 4; i++) expect_ack(1, 16'h5A5A);
    expect_ack(0, 16'h0);
    expect_ack(1, 16'h5A5A);
    serve(60);
    req_lock = 4'b0;

    // Field change during ACCESS is ignored
    set_req(0, 1'b1, 2'd0, 16'hAAAA);
    req = 4'b0001;
    expect_ack(0, 16'h0);
    @(posedge clk);
    #1;
    req_addr[1:0]   = 2'd3;
    req_wdata[15:0] = 16'h5555;
    @(negedge clk);
    check("hold_addr",  {30'b0, rf_addr}, 32'd0);
    check("hold_wdata", {16'b0, rf_wdata}, 32'h0000AAAA);
    check("hold_wr",    {31'b0, rf_wr}, 32'd1);
    rem[0] = 1;
    serve(20);

    set_req(0, 1'b0, 2'd0, 16'h0);
    req = 4'b0001;
    expect_ack(0, 16'hAAAA);
    rem[0] = 1;
    serve(20);

    set_req(0, 1'b0, 2'd3, 16'h0);
    req = 4'b0001;
    expect_ack(0, 16'h0F0F);
    rem[0] = 1;
    serve(20);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
